// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and limits for the packet-granular AXI4-Stream arbiter.
package axis_packet_arbiter_pkg;

  localparam int unsigned MAX_INPUTS        = 16;
  localparam int unsigned STATS_COUNT_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority pick: first set request strictly after 'last' in
// ascending circular order. Purely combinational, reusable by other arbiters.
module rr_priority_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] cand;

  // Walk offsets 1..N from 'last'; the smallest offset with a request wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last) + k) % N);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream egress between
// NUM_INPUTS upstream streams. The grant is held from a packet's first beat to
// its tlast beat; the datapath is a pure combinational mux.
// Optional per-input completed-packet counters: define AXIS_PACKET_ARBITER_STATS_EN.
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_INPUTS-1:0]             s_tvalid,
  output logic [NUM_INPUTS-1:0]             s_tready,
  input  logic [NUM_INPUTS-1:0]             s_tlast,
  input  logic [NUM_INPUTS*DATA_BYTES*8-1:0] s_tdata,
  input  logic [NUM_INPUTS*DATA_BYTES-1:0]  s_tkeep,
  input  logic [NUM_INPUTS*USER_WIDTH-1:0]  s_tuser,
  input  logic [NUM_INPUTS*ID_WIDTH-1:0]    s_tid,
  input  logic [NUM_INPUTS*DEST_WIDTH-1:0]  s_tdest,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic [DATA_BYTES*8-1:0]           m_tdata,
  output logic [DATA_BYTES-1:0]             m_tkeep,
  output logic [DATA_BYTES-1:0]             m_tstrb,
  output logic [USER_WIDTH-1:0]             m_tuser,
  output logic [ID_WIDTH-1:0]               m_tid,
  output logic [DEST_WIDTH-1:0]             m_tdest,
  output logic [$clog2(NUM_INPUTS)-1:0]     grant,
  output logic                              busy
`ifdef AXIS_PACKET_ARBITER_STATS_EN
  ,
  output logic [NUM_INPUTS*STATS_COUNT_WIDTH-1:0] pkt_count
`endif
);

  localparam int unsigned GW = $clog2(NUM_INPUTS);
  localparam int unsigned DW = DATA_BYTES * 8;

  // Reject configurations outside the supported range at elaboration.
  if (NUM_INPUTS < 2 || NUM_INPUTS > MAX_INPUTS) begin : g_bad_num_inputs
    $error("axis_packet_arbiter: NUM_INPUTS must be within 2..16");
  end
  if (DATA_BYTES == 0) begin : g_bad_data_bytes
    $error("axis_packet_arbiter: DATA_BYTES must be at least 1");
  end

  arb_state_t    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] next_grant;
  logic          req_found;
  logic          pkt_done;

  logic [DW-1:0]         data_arr [NUM_INPUTS];
  logic [DATA_BYTES-1:0] keep_arr [NUM_INPUTS];
  logic [USER_WIDTH-1:0] user_arr [NUM_INPUTS];
  logic [ID_WIDTH-1:0]   id_arr   [NUM_INPUTS];
  logic [DEST_WIDTH-1:0] dest_arr [NUM_INPUTS];

  // Split the packed per-input buses into indexable per-input views.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign data_arr[i] = s_tdata[i*DW +: DW];
    assign keep_arr[i] = s_tkeep[i*DATA_BYTES +: DATA_BYTES];
    assign user_arr[i] = s_tuser[i*USER_WIDTH +: USER_WIDTH];
    assign id_arr[i]   = s_tid[i*ID_WIDTH +: ID_WIDTH];
    assign dest_arr[i] = s_tdest[i*DEST_WIDTH +: DEST_WIDTH];
  end

  rr_priority_select #(
    .N  (NUM_INPUTS),
    .IW (GW)
  ) u_select (
    .req   (s_tvalid),
    .last  (last_grant),
    .idx   (next_grant),
    .found (req_found)
  );

  // Payload mux follows the grant; it is only qualified by m_tvalid.
  assign m_tdata = data_arr[grant];
  assign m_tkeep = keep_arr[grant];
  assign m_tuser = user_arr[grant];
  assign m_tid   = id_arr[grant];
  assign m_tdest = dest_arr[grant];
  assign m_tlast = s_tlast[grant];
  assign m_tstrb = '1;

  // Handshake routing: only the granted input sees m_tready, only in PASS.
  always_comb begin
    m_tvalid = 1'b0;
    s_tready = '0;
    if (state == PASS) begin
      m_tvalid        = s_tvalid[grant];
      s_tready[grant] = m_tready;
    end
  end

  assign pkt_done = m_tvalid & m_tready & m_tlast;

  // Grant FSM: pick in IDLE, hold through PASS until the tlast handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_INPUTS - 1);
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_found) begin
            grant <= next_grant;
            state <= PASS;
            busy  <= 1'b1;
          end
        end
        PASS: begin
          if (pkt_done) begin
            last_grant <= grant;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_PACKET_ARBITER_STATS_EN
  // Per-input completed-packet counters, wrapping at 2^32.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_stats
    logic [STATS_COUNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
      if (rst) begin
        count <= '0;
      end else if (pkt_done && (grant == GW'(i))) begin
        count <= count + STATS_COUNT_WIDTH'(1);
      end
    end

    assign pkt_count[i*STATS_COUNT_WIDTH +: STATS_COUNT_WIDTH] = count;
  end
`else
  // Statistics disabled: no counters and no pkt_count port.
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: randomized traffic against a
// transaction-level round-robin model plus directed reset scenarios.
module tb_axis_packet_arbiter;

  localparam int NI  = 4;
  localparam int DB  = 4;
  localparam int UW  = 4;
  localparam int IW  = 2;
  localparam int DSW = 3;
  localparam int GW  = 2;
  localparam int BW  = DB*8 + DB + UW + IW + DSW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI-1:0]     s_tvalid, s_tready, s_tlast;
  logic [NI*DB*8-1:0] s_tdata;
  logic [NI*DB-1:0]  s_tkeep;
  logic [NI*UW-1:0]  s_tuser;
  logic [NI*IW-1:0]  s_tid;
  logic [NI*DSW-1:0] s_tdest;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DB*8-1:0]   m_tdata;
  logic [DB-1:0]     m_tkeep, m_tstrb;
  logic [UW-1:0]     m_tuser;
  logic [IW-1:0]     m_tid;
  logic [DSW-1:0]    m_tdest;
  logic [GW-1:0]     grant;
  logic              busy;
`ifdef AXIS_PACKET_ARBITER_STATS_EN
  logic [NI*32-1:0]  pkt_count;
`endif

  int total = 0;
  int bad   = 0;
  int plen [NI][$];

  axis_packet_arbiter #(
    .NUM_INPUTS (NI), .DATA_BYTES (DB), .USER_WIDTH (UW),
    .ID_WIDTH (IW), .DEST_WIDTH (DSW)
  ) dut (
    .clk (clk), .rst (rst),
    .s_tvalid (s_tvalid), .s_tready (s_tready), .s_tlast (s_tlast),
    .s_tdata (s_tdata), .s_tkeep (s_tkeep), .s_tuser (s_tuser),
    .s_tid (s_tid), .s_tdest (s_tdest),
    .m_tvalid (m_tvalid), .m_tready (m_tready), .m_tlast (m_tlast),
    .m_tdata (m_tdata), .m_tkeep (m_tkeep), .m_tstrb (m_tstrb),
    .m_tuser (m_tuser), .m_tid (m_tid), .m_tdest (m_tdest),
    .grant (grant), .busy (busy)
`ifdef AXIS_PACKET_ARBITER_STATS_EN
    , .pkt_count (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected beat contents: {data, keep, user, id, dest, last}.
  function automatic logic [BW-1:0] beat_word(input int i, input int p, input int b, input int len);
    logic [31:0] d;
    logic [3:0]  k;
    logic        lst;
    lst = (b == len - 1);
    d   = {4'(i), 12'(p), 16'(b)};
    k   = lst ? (4'(p) | 4'b0001) : 4'hf;
    return {d, k, 4'(p + b), 2'(i), 3'(p * 3 + b), lst};
  endfunction

  task automatic drive_src(input int i, input logic v, input logic [BW-1:0] w);
    s_tvalid[i]          = v;
    s_tdata[i*32 +: 32]  = w[45:14];
    s_tkeep[i*4 +: 4]    = w[13:10];
    s_tuser[i*4 +: 4]    = w[9:6];
    s_tid[i*2 +: 2]      = w[5:4];
    s_tdest[i*3 +: 3]    = w[3:1];
    s_tlast[i]           = w[0];
  endtask

  task automatic clear_inputs();
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0;
    s_tuser = '0; s_tid = '0; s_tdest = '0; m_tready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_plen();
    for (int i = 0; i < NI; i++) plen[i].delete();
  endtask

  // Drives the packets in plen[] and checks every cycle against a
  // transaction-level model: precomputed round-robin grant order, one idle
  // cycle after each packet, beats passed through unmodified.
  task automatic run_traffic(input string tag, input int ready_pct, input int gap_pct,
                             input int stall_src, input int stall_cycles);
    int glist[$];
    int rem[NI];
    int pidx[NI];
    int bptr[NI];
    bit [NI-1:0] drv_v;
    int last, g, owner, stall_left, cyc, len;
    bit bubble, done, in_pkt, fire, picked;
    logic exp_v;
    logic [NI-1:0] exp_rdy;
    logic [BW-1:0] exp_w, got_w;

    do_reset();
    last = NI - 1;
    for (int i = 0; i < NI; i++) begin
      rem[i] = plen[i].size(); pidx[i] = 0; bptr[i] = 0;
    end
    do begin
      picked = 1'b0;
      owner  = 0;
      for (int k = 1; k <= NI; k++) begin
        if (!picked && rem[(last + k) % NI] > 0) begin
          owner  = (last + k) % NI;
          picked = 1'b1;
        end
      end
      if (picked) begin
        glist.push_back(owner); rem[owner]--; last = owner;
      end
    end while (picked);

    g = 0; bubble = 1'b1; stall_left = stall_cycles; cyc = 0;
    while (1) begin
      @(negedge clk);
      done = (g >= glist.size());
      for (int i = 0; i < NI; i++) begin
        if (pidx[i] < plen[i].size()) begin
          len      = plen[i][pidx[i]];
          drv_v[i] = 1'b1;
          if (bptr[i] > 0) begin
            if (i == stall_src && bptr[i] == 1 && stall_left > 0) begin
              drv_v[i] = 1'b0; stall_left--;
            end else if ($urandom_range(99) < gap_pct) begin
              drv_v[i] = 1'b0;
            end
          end
          drive_src(i, drv_v[i], beat_word(i, pidx[i], bptr[i], len));
        end else begin
          drv_v[i] = 1'b0;
          drive_src(i, 1'b0, '0);
        end
      end
      m_tready = ($urandom_range(99) < ready_pct);
      #1;
      in_pkt  = !done && !bubble;
      owner   = in_pkt ? glist[g] : 0;
      exp_v   = in_pkt && drv_v[owner];
      exp_rdy = (in_pkt && m_tready) ? (4'b0001 << owner) : 4'b0000;

      total++;
      if (m_tvalid !== exp_v) begin
        bad++; $display("FAIL %s m_tvalid cyc=%0d got=%b exp=%b", tag, cyc, m_tvalid, exp_v);
      end
      total++;
      if (s_tready !== exp_rdy) begin
        bad++; $display("FAIL %s s_tready cyc=%0d got=%b exp=%b", tag, cyc, s_tready, exp_rdy);
      end
      total++;
      if (busy !== in_pkt) begin
        bad++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, busy, in_pkt);
      end
      if (in_pkt) begin
        total++;
        if (grant !== GW'(owner)) begin
          bad++; $display("FAIL %s grant cyc=%0d got=%0d exp=%0d", tag, cyc, grant, owner);
        end
      end
      if (exp_v) begin
        exp_w = beat_word(owner, pidx[owner], bptr[owner], plen[owner][pidx[owner]]);
        got_w = {m_tdata, m_tkeep, m_tuser, m_tid, m_tdest, m_tlast};
        total++;
        if (got_w !== exp_w) begin
          bad++; $display("FAIL %s beat cyc=%0d got=%h exp=%h", tag, cyc, got_w, exp_w);
        end
      end
      if (done) break;

      fire = exp_v && m_tready;
      if (fire) begin
        if (bptr[owner] == plen[owner][pidx[owner]] - 1) begin
          bptr[owner] = 0; pidx[owner]++; g++; bubble = 1'b1;
        end else begin
          bptr[owner]++;
        end
      end else if (!in_pkt) begin
        bubble = 1'b0;
      end

      cyc++;
      if (cyc > 20000) begin
        total++; bad++;
        $display("FAIL %s timeout got=%0d packets exp=%0d", tag, g, glist.size());
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    s_tvalid = '1;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset m_tvalid got=%b exp=0", m_tvalid); end
    total++; if (s_tready !== '0)   begin bad++; $display("FAIL reset s_tready got=%b exp=0", s_tready); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    total++; if (grant !== '0)      begin bad++; $display("FAIL reset grant got=%0d exp=0", grant); end
    total++; if (m_tstrb !== 4'hf)  begin bad++; $display("FAIL reset m_tstrb got=%h exp=f", m_tstrb); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single();
    clear_plen();
    plen[2].push_back(3);
    run_traffic("single", 100, 0, -1, 0);
  endtask

  task automatic test_round_robin();
    clear_plen();
    for (int i = 0; i < NI; i++) repeat (3) plen[i].push_back(2);
    run_traffic("round_robin", 100, 0, -1, 0);
  endtask

  task automatic test_stall();
    clear_plen();
    plen[1].push_back(3);
    plen[3].push_back(3);
    run_traffic("stall", 100, 0, 1, 5);
  endtask

  task automatic test_random();
    clear_plen();
    for (int i = 0; i < NI; i++)
      repeat (250) plen[i].push_back(int'($urandom_range(1, 6)));
    run_traffic("random", 50, 25, -1, 0);
  endtask

  task automatic test_reset_midpacket();
    clear_plen();
    plen[1].push_back(2);
    run_traffic("pre_reset", 100, 0, -1, 0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      drive_src(2, 1'b1, beat_word(2, 0, b, 4));
      m_tready = 1'b1;
      #1;
      total++;
      if (m_tvalid !== 1'b0) begin bad++; $display("FAIL midrst idle m_tvalid got=%b exp=0", m_tvalid); end
      break;
    end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      drive_src(2, 1'b1, beat_word(2, 0, b, 4));
      if (b == 2) rst = 1'b1;
      #1;
      total++;
      if (grant !== 2'd2 || m_tvalid !== 1'b1 || s_tready !== 4'b0100) begin
        bad++; $display("FAIL midrst beat%0d got grant=%0d v=%b rdy=%b exp grant=2 v=1 rdy=0100",
                        b, grant, m_tvalid, s_tready);
      end
    end
    @(posedge clk);
    #1;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL midrst m_tvalid got=%b exp=0", m_tvalid); end
    total++; if (s_tready !== '0)   begin bad++; $display("FAIL midrst s_tready got=%b exp=0", s_tready); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL midrst busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    drive_src(0, 1'b1, beat_word(0, 0, 0, 4));
    drive_src(2, 1'b1, beat_word(2, 0, 0, 4));
    drive_src(3, 1'b1, beat_word(3, 0, 0, 4));
    #1;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL midrst post idle got=%b exp=0", m_tvalid); end
    @(posedge clk);
    #1;
    total++; if (grant !== 2'd0) begin bad++; $display("FAIL midrst next grant got=%0d exp=0", grant); end
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL midrst next busy got=%b exp=1", busy); end
    do_reset();
  endtask

`ifdef AXIS_PACKET_ARBITER_STATS_EN
  task automatic test_stats();
    int exp_cnt [NI];
    logic [31:0] got;
    clear_plen();
    repeat (7) plen[0].push_back(int'($urandom_range(1, 4)));
    repeat (3) plen[3].push_back(int'($urandom_range(1, 4)));
    exp_cnt = '{7, 0, 0, 3};
    run_traffic("stats", 70, 10, -1, 0);
    for (int i = 0; i < NI; i++) begin
      got = pkt_count[i*32 +: 32];
      total++;
      if (got !== 32'(exp_cnt[i])) begin
        bad++; $display("FAIL stats pkt_count[%0d] got=%0d exp=%0d", i, got, exp_cnt[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_random();
    test_reset_midpacket();
`ifdef AXIS_PACKET_ARBITER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-granular round-robin arbiter that shares one downstream AXI4-Stream datapath (typically a width adapter feeding a single egress) between `NUM_INPUTS` upstream streams. A grant is held from the first beat of a packet until its `tlast` beat, so packets never interleave at the output. The block sits directly in front of the shared adapter and adds no datapath register. Only the grant decision is sequential.

## Interface
Parameters:
- `NUM_INPUTS`, 4, number of requesting streams (2..16).
- `DATA_BYTES`, 8, tdata width in bytes, common to all ports.
- `USER_WIDTH`, 1; `ID_WIDTH`, 1; `DEST_WIDTH`, 1, sideband widths, common to all ports.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `s_tvalid/s_tready/s_tlast`  in/out/in  `NUM_INPUTS`  per-input handshake and last.
- `s_tdata`  in  `NUM_INPUTS*DATA_BYTES*8`  packed per input, input i at slice i.
- `s_tkeep`  in  `NUM_INPUTS*DATA_BYTES`  packed.
- `s_tuser/s_tid/s_tdest`  in  `NUM_INPUTS*` respective width  packed.
- `m_tvalid/m_tready/m_tlast`  out/in/out  1  shared output.
- `m_tdata/m_tkeep/m_tuser/m_tid/m_tdest`  out  matching widths  shared output; `m_tstrb` is tied to all ones.
- `grant`  out  `$clog2(NUM_INPUTS)`  index of the current or last granted input.
- `busy`  out  1  high while a packet is in flight (PASS state).

## Operation
- FSM states are IDLE and PASS.
- IDLE:
  - `m_tvalid`=0 and all `s_tready`=0.
  - If any `s_tvalid` is high, select the first requester strictly after `last_grant` in ascending circular order, register it into `grant`, and move to PASS.
- PASS:
  - `m_*` = `s_*[grant]`, combinational mux.
  - `s_tready[grant]` = `m_tready`; all other `s_tready` = 0.
  - On `m_tvalid & m_tready & m_tlast`, set `last_grant` to `grant` and return to IDLE.
- A requester deasserting `tvalid` mid-packet keeps the grant. No timeout and no preemption.
- A request in IDLE is only sampled in IDLE. Requests arriving during PASS wait.
- Fairness: with all inputs continuously requesting, each input receives exactly one packet per `NUM_INPUTS` grants.
- Sideband (`tuser`, `tid`, `tdest`) passes per beat, unmodified.

## Timing
- Reset values:
  - state = IDLE.
  - `grant` = 0.
  - `last_grant` = `NUM_INPUTS-1`, so input 0 wins first.
  - `busy` = 0, `m_tvalid` = 0, all `s_tready` = 0.
- Arbitration latency: request visible in cycle N (state IDLE) gives PASS and a valid mux in cycle N+1. The first beat can complete in N+1.
- Every packet end costs exactly one IDLE bubble cycle before the next grant.
- A single-beat packet (`tlast` on the first beat) occupies one PASS cycle plus one IDLE cycle.
- `m_tready` low stalls the granted input combinationally. There is no buffering.
- `rst` asserted mid-packet: next cycle state is IDLE and all readys are 0. The partially transferred packet is truncated, and recovering from that is the upstream's responsibility.
- Datapath is fully combinational from `s_*` to `m_*`, and from `m_tready` to `s_tready`.

## Configuration
- Macro: `AXIS_PACKET_ARBITER_STATS_EN`.
- Defined:
  - Adds output `pkt_count`, `NUM_INPUTS*32` bits.
  - Per-input 32-bit counter increments on each completed `tlast` handshake for that input.
  - Counters wrap at 2^32 and reset to 0 on `rst`.
- Undefined: the port and the counters are absent, with zero logic cost. Arbitration behaviour is identical either way.

## Structure
- Package `axis_packet_arbiter_pkg` holds:
  - `typedef enum logic {IDLE, PASS} arb_state_t`.
  - Parameter limits `MAX_INPUTS=16` and `STATS_COUNT_WIDTH=32`.
- Sub-module `rr_priority_select`: combinational, takes the request vector and `last_grant`, and outputs the next index plus a `found` flag. It is reusable by other arbiters.
- Elaboration checks enforce `NUM_INPUTS` in 2..16 and `DATA_BYTES` ≥ 1.

## Test plan
- Reset then one request: input 2 sends a 3-beat packet → `grant`=2 and `busy`=1 one cycle after `s_tvalid[2]`; 3 output beats with identical data; `busy`=0 after the `tlast` beat.
- All four inputs request continuously with 2-beat packets → grant order 0,1,2,3,0,…, each grant separated by exactly one idle cycle; no `s_tready` asserted on a non-granted input.
- Input 1 stalls mid-packet (`tvalid`=0 for 5 cycles) while input 3 requests → input 1 keeps the grant, input 3 granted only after input 1's `tlast`.
- Random `m_tready` backpressure (50%) over 1000 packets from 4 inputs → scoreboard sees each packet intact and in order per input, with no interleaving.
- `rst` asserted on beat 2 of a 4-beat packet → state IDLE next cycle, `m_tvalid`=0, and the next grant goes to input 0.
- With `AXIS_PACKET_ARBITER_STATS_EN` defined, 7 packets on input 0 and 3 on input 3 → `pkt_count` slices read 7,0,0,3.
